// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID-stage operands/control, pipeline controls and the registered EX-stage view.
interface id_ex_pipe_reg_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic stall, flush, controlMux, clearCount;
  logic [WIDTH-1:0] idPc, idRsData, idRtData, idImm;
  logic [4:0] idRs, idRt, idRd;
  logic idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst, idBranch;
  logic [3:0] idAluOp;
  logic [WIDTH-1:0] idExPc, idExRsData, idExRtData, idExImm;
  logic [4:0] idExRs, idExRt, idExRd;
  logic idExRegWrite, idExMW, idExMemWrite, idExMemToReg, idExAluSrc, idExRegDst, idExBranch;
  logic [3:0] idExAluOp;
  logic idExValid;
  logic [CNT_W-1:0] bubbleCount;
  modport master (
    output stall, flush, controlMux, clearCount, idPc, idRsData, idRtData, idImm, idRs, idRt, idRd,
           idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst, idBranch, idAluOp,
    input  idExPc, idExRsData, idExRtData, idExImm, idExRs, idExRt, idExRd, idExRegWrite, idExMW,
           idExMemWrite, idExMemToReg, idExAluSrc, idExRegDst, idExBranch, idExAluOp, idExValid, bubbleCount
  );
  modport slave (
    input  stall, flush, controlMux, clearCount, idPc, idRsData, idRtData, idImm, idRs, idRt, idRd,
           idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst, idBranch, idAluOp,
    output idExPc, idExRsData, idExRtData, idExImm, idExRs, idExRt, idExRd, idExRegWrite, idExMW,
           idExMemWrite, idExMemToReg, idExAluSrc, idExRegDst, idExBranch, idExAluOp, idExValid, bubbleCount
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with flush > stall > bubble > load priority and a saturating bubble counter.
module id_ex_pipe_reg #(parameter int WIDTH = 32, parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  id_ex_pipe_reg_if.slave bus
);
  logic [WIDTH-1:0] pc, rsData, rtData, imm;
  logic [4:0] rs, rt, rd;
  logic [10:0] ctrl, idCtrl;
  logic valid;
  logic [CNT_W-1:0] cnt;
  assign idCtrl = {bus.idRegWrite, bus.idMemRead, bus.idMemWrite, bus.idMemToReg,
                   bus.idAluSrc, bus.idRegDst, bus.idBranch, bus.idAluOp};
  // Bubbles still capture datapath fields so EX never sees stale operands.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {pc, rsData, rtData, imm, rs, rt, rd, ctrl, valid} <= '0;
    else if (bus.flush) {pc, rsData, rtData, imm, rs, rt, rd, ctrl, valid} <= '0;
    else if (!bus.stall) begin
      {pc, rsData, rtData, imm, rs, rt, rd} <= {bus.idPc, bus.idRsData, bus.idRtData, bus.idImm,
                                                bus.idRs, bus.idRt, bus.idRd};
      ctrl <= bus.controlMux ? idCtrl : '0;
      valid <= bus.controlMux;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!bus.stall)
      cnt <= bus.clearCount ? '0 : (!bus.flush && !bus.controlMux && cnt != '1) ? cnt + 1'b1 : cnt;
  assign {bus.idExPc, bus.idExRsData, bus.idExRtData, bus.idExImm} = {pc, rsData, rtData, imm};
  assign {bus.idExRs, bus.idExRt, bus.idExRd} = {rs, rt, rd};
  assign {bus.idExRegWrite, bus.idExMW, bus.idExMemWrite, bus.idExMemToReg,
          bus.idExAluSrc, bus.idExRegDst, bus.idExBranch, bus.idExAluOp} = ctrl;
  assign bus.idExValid = valid;
  assign bus.bubbleCount = cnt;
endmodule
